// File: rtl/c_drain_stream.sv
// c_drain_stream: walks the C buffer readback port in row-major order after
// the matrix core finishes and re-emits each accumulator as a narrowed
// valid/ready stream with a last marker.
//
// Optional feature macro: C_DRAIN_SAT_EN
//   defined   -> signed saturation to OUT_W bits, sat_o is sticky per drain
//   undefined -> two's-complement truncation to OUT_W bits, sat_o tied low
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start_i; all outputs quiet
// S_RUN   | issuing C reads 0..cnt-1, throttled by FIFO credit
// S_DRAIN | all reads issued; waiting for the FIFO and read pipe to empty

module c_drain_stream #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [$clog2(N*N):0]    count_i,
  output logic                    c_rd_en,
  output logic [$clog2(N*N)-1:0]  c_rd_addr,
  input  logic [ACC_W-1:0]        c_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sat_o
);

  localparam int NN    = N * N;
  localparam int AW    = $clog2(NN);
  localparam int CW    = AW + 1;
  localparam int DEPTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // control state
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    issue_q, issue_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rd_vld_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // result FIFO
  logic [OUT_W-1:0] fifo_data_q [DEPTH];
  logic [OUT_W-1:0] fifo_data_d [DEPTH];
  logic [DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       fill_q, fill_d;

  // registered stream head
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             start_acc;
  logic [CW-1:0]    count_lim;
  logic             push;
  logic             pop;
  logic             wr_last;
  logic             credit_ok;
  logic [OUT_W-1:0] narrow_data;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign count_lim = (count_i > CW'(NN)) ? CW'(NN) : count_i;

  // read data is valid exactly one cycle after the strobe
  assign push    = rd_vld_q;
  assign pop     = out_valid_q & out_ready;
  assign wr_last = (wr_cnt_q == (cnt_q - CW'(1)));

`ifdef C_DRAIN_SAT_EN
  logic [ACC_W-OUT_W:0] acc_hi;
  logic                 narrow_clamp;
  logic                 sat_q, sat_d;

  // every bit from the OUT_W sign position up must agree or the value is out of range
  assign acc_hi       = c_rd_data[ACC_W-1:OUT_W-1];
  assign narrow_clamp = !((&acc_hi) || !(|acc_hi));

  // saturate out-of-range accumulators to the nearest representable extreme
  always_comb begin
    narrow_data = c_rd_data[OUT_W-1:0];
    if (narrow_clamp) begin
      narrow_data = c_rd_data[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // sticky clamp flag, cleared by each accepted start
  always_comb begin
    sat_d = sat_q;
    if (start_acc) begin
      sat_d = 1'b0;
    end else if (push && narrow_clamp) begin
      sat_d = 1'b1;
    end
  end

  // clamp flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  logic unused_hi;

  // the upper accumulator bits are intentionally dropped (wrap)
  assign unused_hi   = ^c_rd_data[ACC_W-1:OUT_W-1];
  assign narrow_data = c_rd_data[OUT_W-1:0];
  assign sat_o       = 1'b0;
`endif

  // FIFO bookkeeping: write returned data, pop on handshake, refresh the head
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    wr_cnt_d    = wr_cnt_q;

    if (start_acc) begin
      wr_cnt_d = '0;
    end

    if (push) begin
      fifo_data_d[wr_ptr_q] = narrow_data;
      fifo_last_d[wr_ptr_q] = wr_last;
      wr_ptr_d              = wr_ptr_q + 2'd1;
      wr_cnt_d              = wr_cnt_q + CW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + 3'd1;
      2'b01:   fill_d = fill_q - 3'd1;
      default: fill_d = fill_q;
    endcase
  end

  // next head of stream; a write into an empty slot at the head bypasses the array
  always_comb begin
    out_valid_d = (fill_d != 3'd0);
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = narrow_data;
        out_last_d = wr_last;
      end else begin
        out_data_d = fifo_data_q[rd_ptr_d];
        out_last_d = fifo_last_q[rd_ptr_d];
      end
    end
  end

  // a read may issue only if every in-flight element still has a FIFO slot
  assign credit_ok = ({1'b0, fill_d} + {3'b000, rd_en_q}) < 4'd4;

  // sequencing: accept start, walk the addresses, then wait for the pipe to empty
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue_d   = issue_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d     = count_lim;
          issue_d   = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = (count_lim == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = issue_q[AW-1:0];
          issue_d   = issue_q + CW'(1);
          if ((issue_q + CW'(1)) == cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // the read issued last cycle has not reached the FIFO yet
        if ((fill_d == 3'd0) && !rd_en_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // control and read-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      issue_q   <= '0;
      wr_cnt_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      issue_q   <= issue_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_en_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // FIFO storage and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
      end
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign c_rd_en   = rd_en_q;
  assign c_rd_addr = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_c_drain_stream.sv
// Bench for c_drain_stream: a C-buffer model with 1-cycle read latency, a
// queue of expected elements built from the drain rules, and one monitor
// process comparing every handshake, the read address walk and the credit
// bound against that queue.

module tb_c_drain_stream;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int NN    = N * N;
  localparam int AW    = 4;
  localparam int CW    = 5;
`ifdef C_DRAIN_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [CW-1:0]    count_i = '0;
  logic             c_rd_en;
  logic [AW-1:0]    c_rd_addr;
  logic [ACC_W-1:0] c_rd_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             busy_o;
  logic             done_o;
  logic             sat_o;

  c_drain_stream #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .count_i   (count_i),
    .c_rd_en   (c_rd_en),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // C buffer model: registered read, data valid the cycle after the strobe
  int mem [NN];
  always @(posedge clk) begin
    if (c_rd_en) c_rd_data <= mem[c_rd_addr];
  end

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q [$];
  int   got_q [$];

  int n_pass = 0;
  int n_total = 0;

  int run_reads, run_xfers, issued_total, xfer_total;
  int first_en_cyc, first_valid_cyc, last_xfer_cyc, done_cyc;
  int t_start;
  bit exp_sat;
  bit prev_valid, prev_ready, prev_last;
  logic [OUT_W-1:0] prev_data;

  int ready_mode = 0;
  int ready_tick = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // narrowing rule applied to plain integers
  function automatic int narrow(input int v, output bit clamped);
    int w;
    clamped = 1'b0;
    if (SAT_ON) begin
      if (v > 32767) begin
        clamped = 1'b1;
        return 32767;
      end
      if (v < -32768) begin
        clamped = 1'b1;
        return -32768;
      end
      return v;
    end
    w = v % 65536;
    if (w > 32767) w -= 65536;
    if (w < -32768) w += 65536;
    return w;
  endfunction

  // downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((ready_tick % 2) == 0) && !(ready_tick >= 12 && ready_tick < 22);
          ready_tick++;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // monitor: compare every meaningful cycle against the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (c_rd_en) begin
          if (first_en_cyc < 0) first_en_cyc = cyc;
          check("rd_addr", c_rd_addr, run_reads);
          run_reads++;
          issued_total++;
          check("credit_le_4", (issued_total - xfer_total) <= 4, 1);
        end
        if (prev_valid && !prev_ready) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'($signed(out_data)), e.data);
            check("out_last", out_last, e.last);
          end
          got_q.push_back(int'($signed(out_data)));
          run_xfers++;
          xfer_total++;
          last_xfer_cyc = cyc;
        end
        if (done_o) done_cyc = cyc;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic start_run(input int n);
    exp_t e;
    bit   c;
    int   eff;
    eff = (n > NN) ? NN : n;
    @(negedge clk);
    #1;
    exp_sat = 1'b0;
    for (int i = 0; i < eff; i++) begin
      e.data = narrow(mem[i], c);
      e.last = (i == eff - 1);
      exp_sat |= c;
      exp_q.push_back(e);
    end
    run_reads = 0;
    run_xfers = 0;
    first_en_cyc = -1;
    first_valid_cyc = -1;
    last_xfer_cyc = -1;
    done_cyc = -1;
    got_q.delete();
    start_i = 1'b1;
    count_i = CW'(n);
    @(posedge clk);
    #1;
    t_start = cyc;
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cyc < 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("done_seen", done_cyc >= 0, 1);
    @(negedge clk);
    #1;
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_c_rd_en", c_rd_en, 0);
    check("rst_c_rd_addr", c_rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sat", sat_o, 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NN; i++) mem[i] = i * 3 - 20;
  endtask

  initial begin
    int k;
    load_ramp();
    issued_total = 0;
    xfer_total = 0;
    done_cyc = -1;
    first_en_cyc = -1;
    first_valid_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full drain, ready held high
    ready_mode = 0;
    start_run(16);
    wait_done(100);
    check("t1_first_en", first_en_cyc, t_start + 1);
    check("t1_first_valid", first_valid_cyc, t_start + 3);
    check("t1_last_xfer", last_xfer_cyc, t_start + 18);
    check("t1_done", done_cyc, t_start + 19);
    check("t1_count", got_q.size(), 16);
    check("t1_first_val", got_q[0], -20);
    check("t1_last_val", got_q[15], 25);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_sat", sat_o, exp_sat);

    // alternate ready with a long stall mid-stream
    ready_mode = 1;
    ready_tick = 0;
    start_run(16);
    wait_done(400);
    check("t2_count", got_q.size(), 16);
    check("t2_mid_val", got_q[7], 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // narrowing of out-of-range accumulators
    ready_mode = 2;
    mem[0] = 70000;
    mem[1] = -70000;
    mem[2] = 32767;
    start_run(3);
    wait_done(200);
    check("t3_count", got_q.size(), 3);
    check("t3_v0", got_q[0], SAT_ON ? 32767 : 4464);
    check("t3_v1", got_q[1], SAT_ON ? -32768 : -4464);
    check("t3_v2", got_q[2], 32767);
    check("t3_sat_lit", sat_o, SAT_ON ? 1 : 0);
    check("t3_sat_model", sat_o, exp_sat);
    load_ramp();

    // empty drain and an over-range count
    ready_mode = 0;
    start_run(0);
    wait_done(20);
    check("t4_zero_done", done_cyc, t_start + 1);
    check("t4_zero_reads", run_reads, 0);
    check("t4_zero_valid", first_valid_cyc, -1);
    check("t4_zero_sat", sat_o, 0);
    start_run(20);
    wait_done(200);
    check("t4_clamp_reads", run_reads, 16);
    check("t4_clamp_xfers", run_xfers, 16);
    check("t4_clamp_last_val", got_q[15], 25);

    // a start pulse while busy must be ignored
    ready_mode = 2;
    start_run(16);
    repeat (6) @(negedge clk);
    #1;
    check("t5_busy_before_pulse", busy_o, 1);
    start_i = 1'b1;
    count_i = CW'(2);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(400);
    check("t5_reads", run_reads, 16);
    check("t5_xfers", run_xfers, 16);
    check("t5_queue_empty", exp_q.size(), 0);

    // asynchronous reset mid-drain, then a clean restart
    ready_mode = 0;
    start_run(16);
    k = 0;
    while (run_xfers < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_5", run_xfers >= 5, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    issued_total = 0;
    xfer_total = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(4);
    wait_done(100);
    check("t6_count", got_q.size(), 4);
    check("t6_v0", got_q[0], -20);
    check("t6_v3", got_q[3], -11);
    check("t6_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (passed %0d of %0d)", n_pass, n_total);
    $fatal(1);
  end

endmodule
